// File: rtl/order_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction fetch cache.
// A hit completes on the cycle after the lookup. A miss issues a single
// memory read, fills the line, and then completes in RESP if the CPU is
// still asking for the same word.
module order_fetch_cache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] order_address,
    output logic [31:0] order_bus,
    output logic        order_read_cplt,
    input  logic        flush,
    output logic [31:0] mem_address,
    output logic        mem_req,
    input  logic [31:0] mem_data,
    input  logic        mem_ack,
    output logic [15:0] miss_cnt
);

    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - IB;

    localparam logic [1:0] LOOKUP = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]       state;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic             cplt_q;
    logic [31:0]      bus_q;
    logic             fill_ok;   // the outstanding fill may still become a valid line

    logic [IB-1:0] idx;
    logic [TW-1:0] tag;
    logic [IB-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          hit;
    logic          resp_cplt;
    logic          unused_addr_bits;

    assign idx      = order_address[IB+1:2];
    assign tag      = order_address[31:IB+2];
    assign fill_idx = mem_address[IB+1:2];
    assign fill_tag = mem_address[31:IB+2];

    // Byte-offset bits never take part in a lookup.
    assign unused_addr_bits = ^{order_address[1:0], mem_address[1:0]};

    // A lookup racing a flush must see an empty cache.
    assign hit = valid[idx] && (tag_mem[idx] == tag) && !flush;

    // RESP completes only if the CPU still wants the word just fetched.
    assign resp_cplt = (state == RESP) && fill_ok &&
                       (order_address[31:2] == mem_address[31:2]);

    assign order_read_cplt = cplt_q | resp_cplt;
    assign order_bus       = bus_q;

    // Control path: FSM, valid bits, memory handshake and fill counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= LOOKUP;
            valid       <= '0;
            cplt_q      <= 1'b0;
            bus_q       <= '0;
            mem_req     <= 1'b0;
            mem_address <= '0;
            miss_cnt    <= '0;
            fill_ok     <= 1'b0;
        end else begin
            cplt_q <= 1'b0;
            case (state)
                LOOKUP: begin
                    if (hit) begin
                        cplt_q <= 1'b1;
                        bus_q  <= data_mem[idx];
                    end else begin
                        mem_address <= {order_address[31:2], 2'b00};
                        mem_req     <= 1'b1;
                        fill_ok     <= 1'b1;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        fill_ok <= 1'b0;
                    end
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        miss_cnt <= miss_cnt + 16'd1;
                        bus_q    <= mem_data;
                        if (fill_ok && !flush) begin
                            valid[fill_idx] <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= LOOKUP;
                end
                default: begin
                    state <= LOOKUP;
                end
            endcase
            // NOTE: this clear comes after the case so that, as the later
            // non-blocking assignment, it overrides any valid bit set above.
            if (flush) begin
                valid <= '0;
            end
        end
    end

    // Line storage: tag and data are written together on an accepted fill.
    // NOTE: tag/data arrays are not reset; the valid bits alone decide
    // whether their contents mean anything, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (rst && (state == FILL) && mem_ack) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_order_fetch_cache.sv
// Self-checking bench for order_fetch_cache (LINES = 16).
// The bench plays both the CPU and the instruction memory. Expected fetch
// words are queued when an access is driven and popped whenever the DUT
// raises order_read_cplt.
module tb_order_fetch_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] order_address;
    logic [31:0] order_bus;
    logic        order_read_cplt;
    logic        flush;
    logic [31:0] mem_address;
    logic        mem_req;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [15:0] miss_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_miss = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    order_fetch_cache #(.LINES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .order_address   (order_address),
        .order_bus       (order_bus),
        .order_read_cplt (order_read_cplt),
        .flush           (flush),
        .mem_address     (mem_address),
        .mem_req         (mem_req),
        .mem_data        (mem_data),
        .mem_ack         (mem_ack),
        .miss_cnt        (miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the edge and any completion
    // is scored against the head of the expected-word queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (order_read_cplt === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_cplt", 32'(order_read_cplt), 32'd0);
            end else begin
                logic [31:0] w;
                w = exp_q.pop_front();
                check("cplt_word", order_bus, w);
            end
        end
    endtask

    // Access expected to hit: completion on the very next cycle, no memory traffic.
    task automatic present_hit(input logic [31:0] addr, input logic [31:0] word, input bit stray_ack);
        order_address = addr;
        mem_ack       = stray_ack;
        mem_data      = 32'hBAD0_0000 | addr;
        exp_q.push_back(word);
        tick();
        mem_ack = 1'b0;
        check("hit_cplt_seen", 32'(exp_q.size()), 32'd0);
        check("hit_no_req", 32'(mem_req), 32'd0);
        check("hit_miss_cnt", 32'(miss_cnt), 32'(exp_miss));
        exp_q.delete();
    endtask

    // Access expected to miss. The memory acks in FILL cycle lat-1.
    // alt != addr: the CPU moves to alt right after the miss.
    // flush_at >= 0: flush pulses in that FILL cycle; -2: flush with the lookup.
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] word, input int lat,
                              input int flush_at, input logic [31:0] alt);
        bit expect_cplt;
        expect_cplt   = (alt == addr) && (flush_at < 0);
        order_address = addr;
        flush         = (flush_at == -2);
        tick();
        flush = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("fill_req", 32'(mem_req), 32'd1);
            check("fill_addr", mem_address, addr);
            if (i == 0 && alt != addr) order_address = alt;
            flush = (i == flush_at);
            if (i == lat - 1) begin
                mem_ack  = 1'b1;
                mem_data = word;
                if (expect_cplt) exp_q.push_back(word);
                exp_miss++;
            end
            tick();
            flush   = 1'b0;
            mem_ack = 1'b0;
        end
        check("resp_cplt", 32'(order_read_cplt), 32'(expect_cplt));
        check("resp_queue", 32'(exp_q.size()), 32'd0);
        check("resp_req_low", 32'(mem_req), 32'd0);
        check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
        tick();
        exp_q.delete();
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        mem_ack       = 1'b0;
        mem_data      = '0;
        order_address = 32'h100;
        repeat (3) tick();
        check("rst_cplt", 32'(order_read_cplt), 32'd0);
        check("rst_bus", order_bus, 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst = 1'b1;

        // Cold miss, then two more lines, then streaming hits (one with a stray ack).
        fetch_miss(32'h100, 32'hDEAD_BEEF, 3, -1, 32'h100);
        fetch_miss(32'h104, 32'h1111_0104, 1, -1, 32'h104);
        fetch_miss(32'h108, 32'h2222_0108, 2, -1, 32'h108);
        present_hit(32'h100, 32'hDEAD_BEEF, 1'b0);
        present_hit(32'h104, 32'h1111_0104, 1'b1);
        present_hit(32'h108, 32'h2222_0108, 1'b0);

        // Conflict: 0x140 evicts 0x100 (both index 0).
        fetch_miss(32'h140, 32'h3333_0140, 2, -1, 32'h140);
        fetch_miss(32'h100, 32'h4444_0100, 2, -1, 32'h100);
        present_hit(32'h100, 32'h4444_0100, 1'b0);
        present_hit(32'h104, 32'h1111_0104, 1'b0);

        // Address change mid-fill: no completion, line still installed.
        fetch_miss(32'h200, 32'h5555_0200, 3, -1, 32'h300);
        present_hit(32'h200, 32'h5555_0200, 1'b0);
        fetch_miss(32'h300, 32'h6666_0300, 2, -1, 32'h300);

        // Flush coinciding with mem_ack: no completion, line stays invalid.
        fetch_miss(32'h400, 32'h7777_0400, 2, 1, 32'h400);
        fetch_miss(32'h400, 32'h7777_0400, 1, -1, 32'h400);
        present_hit(32'h400, 32'h7777_0400, 1'b0);
        // The earlier flush also dropped 0x104.
        fetch_miss(32'h104, 32'h8888_0104, 1, -1, 32'h104);

        // Flush early in FILL, then a lookup racing a flush.
        fetch_miss(32'h108, 32'h9999_0108, 3, 0, 32'h108);
        fetch_miss(32'h108, 32'h9999_0108, 1, -1, 32'h108);
        fetch_miss(32'h108, 32'hAAAA_0108, 2, -2, 32'h108);
        present_hit(32'h108, 32'hAAAA_0108, 1'b0);

        // Reset in the middle of a fill; a stray ack right after is ignored.
        order_address = 32'h500;
        tick();
        check("pre_rst_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        tick();
        exp_miss = 0;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst      = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 32'hBAD0_0500;
        tick();
        mem_ack = 1'b0;
        check("post_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("post_rst_refetch", 32'(mem_req), 32'd1);
        mem_ack  = 1'b1;
        mem_data = 32'hC0DE_0500;
        exp_q.push_back(32'hC0DE_0500);
        exp_miss++;
        tick();
        mem_ack = 1'b0;
        check("post_rst_resp", 32'(exp_q.size()), 32'd0);
        check("post_rst_fill_cnt", 32'(miss_cnt), 32'(exp_miss));
        tick();
        exp_q.delete();
        // Lines filled before the reset must be gone.
        fetch_miss(32'h104, 32'h1234_0104, 1, -1, 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
